// File: rtl/binary_pkg.sv
// binary_pkg: shared types and constants for the binary arithmetic primitives
package binary_pkg;
   localparam int DEF_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   pr,
   input  logic [WIDTH-1:0] qr,
   input  logic [WIDTH-1:0] dv,
   output logic [WIDTH:0]   pr_next,
   output logic [WIDTH-1:0] qr_next
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] one;
   logic             neg;
   // shift in the next dividend bit and try to subtract the divisor
   always_comb begin
      one     = WIDTH'(1);
      shifted = {pr[WIDTH-1:0], qr[WIDTH-1]};
      trial   = shifted - {1'b0, dv};
      neg     = trial[WIDTH] & ~pr[WIDTH];
      pr_next = neg ? shifted : trial;
      qr_next = (qr << 1) | (neg ? '0 : one);
   end
endmodule

// File: rtl/seq_div.sv
// seq_div: iterative unsigned divider, one quotient bit per cycle
module seq_div
   import binary_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             _go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rem,
   output logic             done
);
   localparam int CW = $clog2(WIDTH) + 1;
   div_state_t       state, nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   pr, step_pr;
   logic [WIDTH-1:0] qr, dv, step_qr;
   logic             accept, last;
   div_step #(.WIDTH(WIDTH)) u_step (
      .pr      (pr),
      .qr      (qr),
      .dv      (dv),
      .pr_next (step_pr),
      .qr_next (step_qr)
   );
   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end
   // next-state: a request is honoured whenever no division is in flight
   always_comb begin
      accept = 1'b0;
      last   = 1'b0;
      nxt    = state;
      accept = (state != BUSY) && _go;
      last   = (state == BUSY) && (cnt == CW'(WIDTH - 1));
      nxt    = accept ? BUSY : (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
   end
   assign done = (state == DONE);
   // datapath: working registers iterate, results publish only on the last step
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         pr  <= '0;
         qr  <= '0;
         dv  <= '0;
         out <= '0;
         rem <= '0;
      end else if (accept) begin
         cnt <= '0;
         pr  <= '0;
         qr  <= left;
         dv  <= right;
      end else if (state == BUSY) begin
         cnt <= cnt + CW'(1);
         pr  <= step_pr;
         qr  <= step_qr;
         if (last) begin
            out <= step_qr;
            rem <= step_pr[WIDTH-1:0];
         end
      end
   end
endmodule
